conv_mac_sequencer: RTL and testbench
=====================================

Name: conv_mac_sequencer

Overview:
- Controller that sequences full linear convolution y[n] = sum_k h[k]*x[n-k] over one shared multiply-accumulate datapath, replacing the fully parallel flattened-bus convolver.
- Generates coefficient and sample memory read addresses, MAC enable/clear strobes and result-memory write strobes.
- Sustains one product per clock with no bubbles between outputs.
- Sits between a start/done host interface and three memories (coefficient, sample, result) plus one registered MAC.

Parameters:
TAPS, 20, number of filter coefficients (>=1)
SIG_LEN, 2401, number of input samples (>=1)
CADDR_W, 5, coefficient address width (2^CADDR_W >= TAPS)
SADDR_W, 12, sample address width (2^SADDR_W >= SIG_LEN)
OADDR_W, 12, result address width (2^OADDR_W >= TAPS+SIG_LEN-1)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a convolution; sampled only in IDLE
busy  out  1  high while a convolution is in progress
done  out  1  one-cycle pulse after the final result write
rd_en  out  1  read strobe to the coefficient and sample memories (1-cycle registered read)
coef_addr  out  CADDR_W  coefficient index k
sig_addr  out  SADDR_W  sample index n-k
mac_en  out  1  MAC updates its accumulator at this clock edge
mac_clr  out  1  with mac_en: acc <= product (first term of an output); else acc <= acc+product
res_we  out  1  write the current accumulator value to result memory
res_addr  out  OADDR_W  output index n for res_we

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs 0; all counters 0. Reset mid-run aborts immediately. No partial done. Result memory contents are don't-care.
- States:
  - IDLE: start=1 -> RUN. n=0, k=0 loaded.
  - RUN: issues one read per cycle. After the read for (n=TAPS+SIG_LEN-2, k=TAPS-1) -> DRAIN.
  - DRAIN: 2 cycles, empties the pipeline.
  - DONE: 1 cycle, done=1 -> IDLE.
  - start is ignored outside IDLE.
- Term ordering:
  - Outputs run n = 0 .. TAPS+SIG_LEN-2.
  - For each n, k ascends from kmin = max(0, n-(SIG_LEN-1)) to kmax = min(n, TAPS-1).
  - Issue coef_addr=k, sig_addr=n-k.
  - After kmax: n increments, k reloads to kmin(n+1), all in the same edge.
  - Compute kmin/kmax incrementally with comparisons, no subtraction-based clamps wider than OADDR_W+1. No multiplier.
- Pipeline: a read issued in cycle t produces:
  - mac_en=1 in cycle t+1;
  - mac_clr=1 in cycle t+1 if that read had k=kmin;
  - res_we=1 with res_addr=n in cycle t+2 if that read had k=kmax.
  - res_we samples the accumulator before the edge at which the next output's first mac_en loads it, so back-to-back outputs need no stall.
- Timing (start sampled at edge E0, P = TAPS*SIG_LEN total terms):
  - rd_en high in cycles 1..P;
  - mac_en in cycles 2..P+1;
  - last res_we in cycle P+2;
  - done=1 and busy=0 in cycle P+3;
  - busy=1 in cycles 1..P+2.
- Outputs are registered. rd_en, mac_en and res_we are 0 whenever idle. Address outputs hold their last value when their strobe is low.
- start held high continuously: a new run starts on the edge after DONE (one IDLE cycle between runs).
- TAPS=1: every cycle has mac_clr=1 and res_we follows each read by 2 cycles.
- SIG_LEN<TAPS is legal; the kmin/kmax clamps handle it.
- res_addr count: exactly TAPS+SIG_LEN-1 distinct writes, in increasing n, each exactly once.

Test Plan:
- TAPS=3, SIG_LEN=4, start pulse. Address pairs (c,s) must be (0,0)(0,1)(1,0)(0,2)(1,1)(2,0)(0,3)(1,2)(2,1)(1,3)(2,2)(2,3). res_we at cycles 3,5,8,11,13,14 with res_addr 0..5. done at cycle 15.
- Same params, bench memory/MAC model with h=[1,2,3], x=[1,1,1,1] -> result memory [1,3,6,6,5,3]. Then h=[1,-1,0], x=[4,3,2,1] -> [4,-1,-1,-1,-1,0].
- TAPS=1, SIG_LEN=5, h=[2], x=[1..5] -> mac_clr on all 5 mac_en cycles. Results [2,4,6,8,10]. done at cycle 8.
- Default params (20, 2401), bench memories loaded from filter_coeff_bin.txt and input.txt -> 2420 writes, done at cycle 48023, results match the golden reference convolution.
- rst_n pulled low at cycle 7 of a TAPS=3, SIG_LEN=4 run -> all outputs 0 asynchronously, no done. Fresh start afterward reproduces scenario 1 exactly.
- start asserted during RUN/DRAIN and held through DONE -> ignored mid-run. Second run's first rd_en occurs 2 cycles after done.

Source files
------------

// File: rtl/conv_mac_sequencer_if.sv
// Host and memory-side signals of the convolution MAC sequencer.
// master = sequencer side, slave = host / memory / MAC side.
interface conv_mac_sequencer_if #(
    parameter int unsigned CADDR_W = 5,
    parameter int unsigned SADDR_W = 12,
    parameter int unsigned OADDR_W = 12
);
    logic               start;
    logic               busy;
    logic               done;
    logic               rd_en;
    logic [CADDR_W-1:0] coef_addr;
    logic [SADDR_W-1:0] sig_addr;
    logic               mac_en;
    logic               mac_clr;
    logic               res_we;
    logic [OADDR_W-1:0] res_addr;

    modport master (
        input  start,
        output busy, done, rd_en, coef_addr, sig_addr, mac_en, mac_clr, res_we, res_addr
    );

    modport slave (
        output start,
        input  busy, done, rd_en, coef_addr, sig_addr, mac_en, mac_clr, res_we, res_addr
    );
endinterface

// File: rtl/conv_mac_sequencer.sv
// Sequences y[n] = sum_k h[k]*x[n-k] over one shared registered MAC, one term per clock.
// Read stage -> MAC stage -> result write stage; back-to-back outputs need no stall.
module conv_mac_sequencer #(
    parameter int unsigned TAPS    = 20,
    parameter int unsigned SIG_LEN = 2401,
    parameter int unsigned CADDR_W = 5,
    parameter int unsigned SADDR_W = 12,
    parameter int unsigned OADDR_W = 12
) (
    input logic                  clk,
    input logic                  rst_n,
    conv_mac_sequencer_if.master bus
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [OADDR_W-1:0] NLast    = OADDR_W'(TAPS + SIG_LEN - 2);
    localparam logic [OADDR_W-1:0] SigLastO = OADDR_W'(SIG_LEN - 1);
    localparam logic [SADDR_W-1:0] SigLastS = SADDR_W'(SIG_LEN - 1);
    localparam logic [CADDR_W-1:0] TapLast  = CADDR_W'(TAPS - 1);
    localparam logic               TailInit = (SIG_LEN == 1);

    logic [1:0]         state_q, state_d;
    logic               drain_q, drain_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic [OADDR_W-1:0] n_q, n_d;
    logic [CADDR_W-1:0] k_q, k_d;
    logic [SADDR_W-1:0] s_q, s_d;
    logic [CADDR_W-1:0] kmin_q, kmin_d;
    logic [CADDR_W-1:0] kmax_q, kmax_d;
    // tail: n has reached SIG_LEN-1, so kmin(n+1) is kmin(n)+1 rather than 0
    logic               tail_q, tail_d;
    logic               mac_en_q, mac_en_d;
    logic               mac_clr_q, mac_clr_d;
    logic               wlast_q, wlast_d;
    logic [OADDR_W-1:0] wn_q, wn_d;
    logic               res_we_q, res_we_d;
    logic [OADDR_W-1:0] res_addr_q, res_addr_d;

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_en_d    = rd_en_q;
        n_d        = n_q;
        k_d        = k_q;
        s_d        = s_q;
        kmin_d     = kmin_q;
        kmax_d     = kmax_q;
        tail_d     = tail_q;
        mac_en_d   = rd_en_q;
        mac_clr_d  = rd_en_q & (k_q == kmin_q);
        wlast_d    = rd_en_q & (k_q == kmax_q);
        wn_d       = rd_en_q ? n_q : wn_q;
        res_we_d   = wlast_q;
        res_addr_d = wlast_q ? wn_q : res_addr_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                    n_d     = '0;
                    k_d     = '0;
                    s_d     = '0;
                    kmin_d  = '0;
                    kmax_d  = '0;
                    tail_d  = TailInit;
                end
            end
            StRun: begin
                if (k_q == kmax_q) begin
                    if (n_q == NLast) begin
                        state_d = StDrain;
                        rd_en_d = 1'b0;
                        drain_d = 1'b0;
                    end else begin
                        n_d    = n_q + 1'b1;
                        tail_d = tail_q | ((n_q + 1'b1) == SigLastO);
                        kmin_d = tail_q ? kmin_q + 1'b1 : '0;
                        kmax_d = (kmax_q != TapLast) ? kmax_q + 1'b1 : kmax_q;
                        k_d    = kmin_d;
                        s_d    = tail_d ? SigLastS : SADDR_W'(n_q + 1'b1);
                    end
                end else begin
                    k_d = k_q + 1'b1;
                    s_d = s_q - 1'b1;
                end
            end
            StDrain: begin
                if (drain_q) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            drain_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            n_q        <= '0;
            k_q        <= '0;
            s_q        <= '0;
            kmin_q     <= '0;
            kmax_q     <= '0;
            tail_q     <= 1'b0;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
            wlast_q    <= 1'b0;
            wn_q       <= '0;
            res_we_q   <= 1'b0;
            res_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            n_q        <= n_d;
            k_q        <= k_d;
            s_q        <= s_d;
            kmin_q     <= kmin_d;
            kmax_q     <= kmax_d;
            tail_q     <= tail_d;
            mac_en_q   <= mac_en_d;
            mac_clr_q  <= mac_clr_d;
            wlast_q    <= wlast_d;
            wn_q       <= wn_d;
            res_we_q   <= res_we_d;
            res_addr_q <= res_addr_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.coef_addr = k_q;
    assign bus.sig_addr  = s_q;
    assign bus.mac_en    = mac_en_q;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.res_we    = res_we_q;
    assign bus.res_addr  = res_addr_q;
endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Bench for conv_mac_sequencer: three parameterisations share one memory/MAC model;
// traces and result memory are checked against a direct convolution reference.
module tb_conv_mac_sequencer;
    typedef struct {int cyc; int a; int b;} ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [2:0]  start_v, rd_en_v, mac_en_v, mac_clr_v, res_we_v, busy_v, done_v;
    logic [31:0] coef_v [3];
    logic [31:0] sig_v [3];
    logic [31:0] raddr_v [3];

    int sel, pc, g0, vectors, miscompares;
    int h_mem [32];
    int x_mem [4096];
    int res_mem [4096];
    int dh, dx, acc;
    ev_t rd_q[$], mac_q[$], we_q[$];
    int done_q[$], busy_q[$];
    int rd_b, mac_b, we_b, done_b, busy_b;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int unsigned Tp = (gi == 0) ? 3 : (gi == 1) ? 1 : 20;
        localparam int unsigned Sl = (gi == 0) ? 4 : (gi == 1) ? 5 : 2401;
        localparam int unsigned Cw = (gi == 0) ? 2 : (gi == 1) ? 1 : 5;
        localparam int unsigned Sw = (gi == 0) ? 2 : (gi == 1) ? 3 : 12;
        localparam int unsigned Ow = (gi == 0) ? 3 : (gi == 1) ? 3 : 12;
        conv_mac_sequencer_if #(.CADDR_W(Cw), .SADDR_W(Sw), .OADDR_W(Ow)) bus ();
        conv_mac_sequencer #(
            .TAPS(Tp), .SIG_LEN(Sl), .CADDR_W(Cw), .SADDR_W(Sw), .OADDR_W(Ow)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .bus(bus)
        );
        assign bus.start     = start_v[gi];
        assign rd_en_v[gi]   = bus.rd_en;
        assign mac_en_v[gi]  = bus.mac_en;
        assign mac_clr_v[gi] = bus.mac_clr;
        assign res_we_v[gi]  = bus.res_we;
        assign busy_v[gi]    = bus.busy;
        assign done_v[gi]    = bus.done;
        assign coef_v[gi]    = 32'(bus.coef_addr);
        assign sig_v[gi]     = 32'(bus.sig_addr);
        assign raddr_v[gi]   = 32'(bus.res_addr);
    end

    // Memories with 1-cycle registered read, registered MAC, result memory.
    always @(posedge clk) begin
        pc <= pc + 1;
        if (rd_en_v[sel] === 1'b1) begin
            dh <= h_mem[coef_v[sel][4:0]];
            dx <= x_mem[sig_v[sel][11:0]];
        end
        if (mac_en_v[sel] === 1'b1) acc <= (mac_clr_v[sel] === 1'b1) ? dh * dx : acc + dh * dx;
        if (res_we_v[sel] === 1'b1) res_mem[raddr_v[sel][11:0]] <= acc;
    end

    always @(negedge clk) begin
        if (rd_en_v[sel] === 1'b1) rd_q.push_back(ev_t'{pc, int'(coef_v[sel]), int'(sig_v[sel])});
        if (mac_en_v[sel] === 1'b1) mac_q.push_back(ev_t'{pc, int'(mac_clr_v[sel]), 0});
        if (res_we_v[sel] === 1'b1) we_q.push_back(ev_t'{pc, int'(raddr_v[sel]), 0});
        if (done_v[sel] === 1'b1) done_q.push_back(pc);
        if (busy_v[sel] === 1'b1) busy_q.push_back(pc);
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int rel(input int abs_cyc);
        return abs_cyc - g0 + 1;
    endfunction

    task automatic mark();
        rd_b   = rd_q.size();
        mac_b  = mac_q.size();
        we_b   = we_q.size();
        done_b = done_q.size();
        busy_b = busy_q.size();
        g0     = pc + 1;
    endtask

    // Start is sampled at the next posedge (E0); cycle 1 follows it.
    task automatic begin_run();
        @(negedge clk);
        mark();
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen == 0; i++) begin
            @(negedge clk);
            if (done_v[sel] === 1'b1) seen = 1;
        end
        check("done_seen", seen, 1);
        tick(3);
    endtask

    function automatic int ref_y(input int t, input int s, input int n);
        int y = 0;
        for (int k = 0; k < t; k++)
            if (n - k >= 0 && n - k < s) y += h_mem[k] * x_mem[n - k];
        return y;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"}, rd_en_v[sel], 0);
        check({tag, "_mac_en"}, mac_en_v[sel], 0);
        check({tag, "_mac_clr"}, mac_clr_v[sel], 0);
        check({tag, "_res_we"}, res_we_v[sel], 0);
        check({tag, "_busy"}, busy_v[sel], 0);
        check({tag, "_done"}, done_v[sel], 0);
        check({tag, "_coef_addr"}, coef_v[sel], 0);
        check({tag, "_sig_addr"}, sig_v[sel], 0);
        check({tag, "_res_addr"}, raddr_v[sel], 0);
    endtask

    task automatic check_trace(input int t, input int s, input string tag);
        int p = t * s;
        int idx = 0;
        int w = 0;
        int kmin, kmax;
        ev_t ev;
        check({tag, "_rd_count"}, rd_q.size() - rd_b, p);
        check({tag, "_mac_count"}, mac_q.size() - mac_b, p);
        check({tag, "_we_count"}, we_q.size() - we_b, t + s - 1);
        check({tag, "_done_count"}, done_q.size() - done_b, 1);
        check({tag, "_busy_count"}, busy_q.size() - busy_b, p + 2);
        if (done_q.size() > done_b) check({tag, "_done_cyc"}, rel(done_q[done_b]), p + 3);
        if (busy_q.size() > busy_b) begin
            check({tag, "_busy_first"}, rel(busy_q[busy_b]), 1);
            check({tag, "_busy_last"}, rel(busy_q[busy_q.size() - 1]), p + 2);
        end
        for (int n = 0; n <= t + s - 2; n++) begin
            kmin = (n > s - 1) ? n - (s - 1) : 0;
            kmax = (n < t - 1) ? n : t - 1;
            for (int k = kmin; k <= kmax; k++) begin
                if (rd_b + idx < rd_q.size()) begin
                    ev = rd_q[rd_b + idx];
                    check({tag, "_rd_cyc"}, rel(ev.cyc), idx + 1);
                    check({tag, "_coef_addr"}, ev.a, k);
                    check({tag, "_sig_addr"}, ev.b, n - k);
                end
                if (mac_b + idx < mac_q.size()) begin
                    ev = mac_q[mac_b + idx];
                    check({tag, "_mac_cyc"}, rel(ev.cyc), idx + 2);
                    check({tag, "_mac_clr"}, ev.a, (k == kmin) ? 1 : 0);
                end
                if (k == kmax) begin
                    if (we_b + w < we_q.size()) begin
                        ev = we_q[we_b + w];
                        check({tag, "_we_cyc"}, rel(ev.cyc), idx + 3);
                        check({tag, "_res_addr"}, ev.a, n);
                    end
                    w++;
                end
                idx++;
            end
        end
        for (int n = 0; n <= t + s - 2; n++) check({tag, "_result"}, res_mem[n], ref_y(t, s, n));
    endtask

    task automatic load_s1();
        for (int i = 0; i < 3; i++) h_mem[i] = i + 1;
        for (int i = 0; i < 4; i++) x_mem[i] = 1;
    endtask

    task automatic check_s1_results(input string tag);
        int exp_y[6] = '{1, 3, 6, 6, 5, 3};
        for (int n = 0; n < 6; n++) check({tag, "_const_result"}, res_mem[n], exp_y[n]);
    endtask

    initial begin
        int exp_y2[6] = '{4, -1, -1, -1, -1, 0};
        int cnt;
        rst_n = 1'b0;
        start_v = '0;
        sel = 0;
        vectors = 0;
        miscompares = 0;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            check_zero("reset");
        end
        rst_n = 1'b1;
        sel = 0;
        tick(2);

        // TAPS=3, SIG_LEN=4: all-ones signal, then a differencing filter, then random data
        load_s1();
        begin_run();
        wait_done(40);
        check_trace(3, 4, "s1");
        check_s1_results("s1");

        h_mem[0] = 1; h_mem[1] = -1; h_mem[2] = 0;
        for (int i = 0; i < 4; i++) x_mem[i] = 4 - i;
        begin_run();
        wait_done(40);
        check_trace(3, 4, "s2");
        for (int n = 0; n < 6; n++) check("s2_const_result", res_mem[n], exp_y2[n]);

        for (int i = 0; i < 3; i++) h_mem[i] = int'($urandom_range(0, 200)) - 100;
        for (int i = 0; i < 4; i++) x_mem[i] = int'($urandom_range(0, 200)) - 100;
        begin_run();
        wait_done(40);
        check_trace(3, 4, "s3");

        // Reset at cycle 7 of a run: outputs drop before any clock edge, no done follows
        load_s1();
        begin_run();
        tick(6);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("rst_mid_no_done", done_q.size() - done_b, 0);
        begin_run();
        wait_done(40);
        check_trace(3, 4, "s4");
        check_s1_results("s4");

        // start re-asserted mid-run and held through DONE
        @(negedge clk);
        mark();
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        tick(4);
        start_v[sel] = 1'b1;
        wait_done(40);
        start_v[sel] = 1'b0;
        if (done_q.size() > done_b) check("s5_first_done_cyc", rel(done_q[done_b]), 15);
        cnt = 0;
        for (int i = rd_b; i < rd_q.size(); i++) if (rel(rd_q[i].cyc) <= 15) cnt++;
        check("s5_first_run_reads", cnt, 12);
        check("s5_second_run_started", (rd_q.size() > rd_b + 12) ? 1 : 0, 1);
        if (rd_q.size() > rd_b + 12) check("s5_second_first_rd", rel(rd_q[rd_b + 12].cyc), 17);
        wait_done(40);
        check("s5_done_count", done_q.size() - done_b, 2);
        if (done_q.size() > done_b + 1) check("s5_second_done_cyc", rel(done_q[done_b + 1]), 31);
        check("s5_rd_total", rd_q.size() - rd_b, 24);
        check_s1_results("s5");

        // TAPS=1, SIG_LEN=5
        sel = 1;
        tick(2);
        h_mem[0] = 2;
        for (int i = 0; i < 5; i++) x_mem[i] = i + 1;
        begin_run();
        wait_done(30);
        check_trace(1, 5, "s6");
        for (int n = 0; n < 5; n++) check("s6_const_result", res_mem[n], 2 * (n + 1));

        // Default parameters with random data
        sel = 2;
        tick(2);
        for (int i = 0; i < 20; i++) h_mem[i] = int'($urandom_range(0, 127)) - 64;
        for (int i = 0; i < 2401; i++) x_mem[i] = int'($urandom_range(0, 2000)) - 1000;
        begin_run();
        wait_done(48100);
        check_trace(20, 2401, "s7");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
